pll_init_multi: RTL and testbench
=================================

# pll_init_multi

Multi-channel PLL bring-up and supervision controller, running on the always-on init clock (50 MHz board oscillator). For each of CHANNELS PLLs it drives reset and the ICPSEL/LPFRES loop-filter settings, sweeping charge-pump current until the PLL locks stably. It then monitors lock, re-calibrates automatically on sustained lock loss, and reports per-channel and aggregate status to the clock/reset tree and the HDMI and core clock domains.

## Interface
- CHANNELS, 2: number of supervised PLLs (1..4).
- RST_CYC, 50: cycles pll_rst is held high per attempt (≥1).
- LOCK_TO_CYC, 5000: cycles to wait for synced lock after reset release before trying the next setting.
- STABLE_CYC, 256: consecutive synced-lock cycles required to declare lock.
- LOST_CYC, 4: consecutive synced-unlock cycles in LOCKED that count as lock loss (glitch filter).
- ICP_BASE, 8: first ICPSEL value tried (6-bit).
- ICP_STEP, 4: ICPSEL increment per failed attempt.
- NUM_TRIES, 8: settings per sweep (1..16).
- LPF_RES, 3'd2: LPFRES driven on all channels.
- init_clk  in  1  free-running init clock; all logic on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pll_lock  in  CHANNELS  raw PLL lock, asynchronous to init_clk.
- recal  in  CHANNELS  per-channel request to restart calibration; level, sampled each cycle.
- pll_rst  out  CHANNELS  PLL reset, active high.
- icpsel  out  6*CHANNELS  charge-pump setting, channel i at [6i+5:6i].
- lpfres  out  3*CHANNELS  loop-filter resistor, channel i at [3i+2:3i].
- lock  out  CHANNELS  channel in LOCKED.
- all_lock  out  1  AND of lock.
- fail  out  CHANNELS  sweep exhausted without lock.
- relock_cnt  out  4*CHANNELS  saturating count of lock-loss events per channel.

## Operation
- Each channel has an independent FSM, a 2-flop synchronizer on pll_lock (lk_s), one shared-width cycle counter, and a 4-bit try index k.
- icpsel = min(ICP_BASE + k*ICP_STEP, 63), registered; lpfres = LPF_RES constant.
- States:
  - HOLD: pll_rst=1; counter runs to RST_CYC-1, then WAIT.
  - WAIT: pll_rst=0; if lk_s, go to STABLE with counter=0; if counter reaches LOCK_TO_CYC-1 without lk_s, go to NEXT.
  - STABLE: lk_s high for STABLE_CYC consecutive cycles → LOCKED; any lk_s=0 → NEXT.
  - NEXT (1 cycle): if k=NUM_TRIES-1 → FAIL, else k+=1 → HOLD.
  - LOCKED: lock=1; LOST_CYC consecutive lk_s=0 → relock_cnt+=1 (saturates at 15), k kept (retry the known-good setting first) → HOLD. Shorter unlock runs are ignored; the run counter clears on lk_s=1.
  - FAIL: fail=1, pll_rst=1; stays until recal.
- recal=1 in any state: next state HOLD, k=0, fail=0, lock=0, counter=0; recal held high keeps the channel in HOLD. recal has priority over all other transitions.
- When a sweep wraps back to HOLD after lock loss and fails, k advances from the retained value, not from 0; reaching NUM_TRIES-1 goes to FAIL.
- Reset values: state HOLD, k=0, counter=0, pll_rst all 1, icpsel = ICP_BASE per channel, lpfres = LPF_RES, lock=0, all_lock=0, fail=0, relock_cnt=0, synchronizers 0.
- Reset asserted mid-operation forces all of the above immediately (asynchronous). relock_cnt is cleared only by resetn, not by recal.

## Timing
- After resetn deasserts, pll_rst stays high for exactly RST_CYC cycles, then drops.
- Lock path latency: pll_lock rise → lk_s after 2 cycles → lock asserts STABLE_CYC cycles after lk_s first high (no lock-loss during that window).
- Timeout: the transition WAIT→NEXT occurs LOCK_TO_CYC cycles after pll_rst falls. pll_rst re-asserts, with the new icpsel, 1 cycle later (NEXT cycle). icpsel changes only while pll_rst=1.
- Lock loss: lock deasserts and pll_rst asserts LOST_CYC+2 cycles after pll_lock falls.
- all_lock is registered; it follows lock by 1 cycle.
- Channels never interact; simultaneous events on different channels are handled independently in the same cycle.

## Test plan
- Default parameters, pll_lock[0] rises 1000 cycles after reset release and stays high → pll_rst[0] high for 50 cycles, lock[0]=1 at lock-rise+2+256, icpsel[0]=8, fail[0]=0.
- pll_lock[1] never rises → icpsel[1] steps 8,12,…,36; 8 attempts of 50+5000+1 cycles; then fail[1]=1, pll_rst[1]=1, lock[0] unaffected.
- In LOCKED, 3-cycle pll_lock glitch → no change. 4-cycle drop → relock_cnt=1, pll_rst pulse, same icpsel retained, relock after 256 stable cycles.
- Set ICP_BASE=60 and let lock come only on try 2 → icpsel saturates at 63 on tries 1 and 2, then locks with icpsel=63.
- With fail[1]=1, pulse recal[1] for 1 cycle → fail clears, k=0, icpsel=8, HOLD restarts. Also pulse recal during STABLE → same restart.
- Assert resetn low during WAIT on both channels → all outputs return to reset values in the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/pll_init_multi_if.sv
// pll_init_multi_if
// Bundles the per-channel PLL control/status signals of pll_init_multi.
//   pll_lock   : raw PLL lock inputs, asynchronous to init_clk
//   recal      : per-channel calibration restart request (level)
//   pll_rst    : PLL reset, active high
//   icpsel     : charge-pump setting, channel i at [6i+5:6i]
//   lpfres     : loop-filter resistor, channel i at [3i+2:3i]
//   lock       : channel locked
//   all_lock   : AND of lock, registered
//   fail       : sweep exhausted without lock
//   relock_cnt : saturating lock-loss count, channel i at [4i+3:4i]
// master = controller side, slave = PLL / supervisor side.
interface pll_init_multi_if #(
  parameter int unsigned CHANNELS = 2
);
  logic [CHANNELS-1:0]   pll_lock;
  logic [CHANNELS-1:0]   recal;
  logic [CHANNELS-1:0]   pll_rst;
  logic [6*CHANNELS-1:0] icpsel;
  logic [3*CHANNELS-1:0] lpfres;
  logic [CHANNELS-1:0]   lock;
  logic                  all_lock;
  logic [CHANNELS-1:0]   fail;
  logic [4*CHANNELS-1:0] relock_cnt;

  modport master (
    input  pll_lock, recal,
    output pll_rst, icpsel, lpfres, lock, all_lock, fail, relock_cnt
  );

  modport slave (
    output pll_lock, recal,
    input  pll_rst, icpsel, lpfres, lock, all_lock, fail, relock_cnt
  );
endinterface

// File: rtl/pll_init_multi.sv
// pll_init_multi
// Multi-channel PLL bring-up and supervision controller on the init clock.
// Each channel sweeps ICPSEL from ICP_BASE in ICP_STEP increments until its
// PLL holds lock for STABLE_CYC cycles, then supervises lock and restarts the
// sweep (from the last good setting) after LOST_CYC cycles of lock loss.
// Ports:
//   init_clk : free-running init clock, all logic on its rising edge
//   resetn   : asynchronous active-low reset
//   pll      : pll_init_multi_if.master bundle (see interface header)
module pll_init_multi #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned RST_CYC     = 50,
  parameter int unsigned LOCK_TO_CYC = 5000,
  parameter int unsigned STABLE_CYC  = 256,
  parameter int unsigned LOST_CYC    = 4,
  parameter int unsigned ICP_BASE    = 8,
  parameter int unsigned ICP_STEP    = 4,
  parameter int unsigned NUM_TRIES   = 8,
  parameter logic [2:0]  LPF_RES     = 3'd2
) (
  input  logic          init_clk,
  input  logic          resetn,
  pll_init_multi_if.master pll
);

  localparam int unsigned MAX_A  = (RST_CYC > LOCK_TO_CYC) ? RST_CYC : LOCK_TO_CYC;
  localparam int unsigned MAX_B  = (STABLE_CYC > LOST_CYC) ? STABLE_CYC : LOST_CYC;
  localparam int unsigned MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W  = $clog2(MAX_C + 1);
  // The WAIT cycle that first sees lk_s is the first stable cycle, so STABLE
  // itself only has to count the remaining STABLE_CYC-1 cycles.
  localparam int unsigned STABLE_LAST = (STABLE_CYC > 1) ? STABLE_CYC - 2 : 0;

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT,
    S_STABLE,
    S_NEXT,
    S_LOCKED,
    S_FAIL
  } state_e;

  function automatic logic [5:0] icp_of(input logic [3:0] k);
    int unsigned v;
    v = ICP_BASE + 32'(k) * ICP_STEP;
    return (v > 63) ? 6'd63 : v[5:0];
  endfunction

  logic [CHANNELS-1:0]   rst_v;
  logic [CHANNELS-1:0]   lock_v;
  logic [CHANNELS-1:0]   fail_v;
  logic [6*CHANNELS-1:0] icp_v;
  logic [4*CHANNELS-1:0] relock_v;
  logic                  all_lock_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       k_q, k_d;
    logic [3:0]       relock_q, relock_d;
    logic [5:0]       icp_q;
    logic [1:0]       sync_q;
    logic             lk_s;

    assign lk_s = sync_q[1];

    always_ff @(posedge init_clk or negedge resetn) begin
      if (!resetn) begin
        state_q  <= S_HOLD;
        cnt_q    <= '0;
        k_q      <= '0;
        relock_q <= '0;
        icp_q    <= icp_of(4'd0);
        sync_q   <= '0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        k_q      <= k_d;
        relock_q <= relock_d;
        icp_q    <= icp_of(k_d);
        sync_q   <= {sync_q[0], pll.pll_lock[c]};
      end
    end

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CNT_W'(1);
      k_d      = k_q;
      relock_d = relock_q;
      if (pll.recal[c]) begin
        state_d = S_HOLD;
        cnt_d   = '0;
        k_d     = '0;
      end else begin
        case (state_q)
          S_HOLD: begin
            if (cnt_q == CNT_W'(RST_CYC - 1)) begin
              state_d = S_WAIT;
              cnt_d   = '0;
            end
          end
          S_WAIT: begin
            if (lk_s) begin
              state_d = S_STABLE;
              cnt_d   = '0;
            end else if (cnt_q == CNT_W'(LOCK_TO_CYC - 1)) begin
              state_d = S_NEXT;
              cnt_d   = '0;
            end
          end
          S_STABLE: begin
            if (!lk_s) begin
              state_d = S_NEXT;
              cnt_d   = '0;
            end else if (cnt_q == CNT_W'(STABLE_LAST)) begin
              state_d = S_LOCKED;
              cnt_d   = '0;
            end
          end
          S_NEXT: begin
            cnt_d = '0;
            if (k_q == 4'(NUM_TRIES - 1)) begin
              state_d = S_FAIL;
            end else begin
              k_d     = k_q + 4'd1;
              state_d = S_HOLD;
            end
          end
          S_LOCKED: begin
            // cnt is the unlock run length; any synced lock clears it.
            if (lk_s) begin
              cnt_d = '0;
            end else if (cnt_q == CNT_W'(LOST_CYC - 1)) begin
              state_d = S_HOLD;
              cnt_d   = '0;
              if (relock_q != 4'hF) relock_d = relock_q + 4'd1;
            end
          end
          S_FAIL: cnt_d = '0;
          default: begin
            state_d = S_HOLD;
            cnt_d   = '0;
          end
        endcase
      end
    end

    assign rst_v[c]         = (state_q == S_HOLD) || (state_q == S_FAIL);
    assign lock_v[c]        = (state_q == S_LOCKED);
    assign fail_v[c]        = (state_q == S_FAIL);
    assign icp_v[6*c +: 6]  = icp_q;
    assign relock_v[4*c +: 4] = relock_q;
  end

  always_ff @(posedge init_clk or negedge resetn) begin
    if (!resetn) all_lock_q <= 1'b0;
    else         all_lock_q <= &lock_v;
  end

  assign pll.pll_rst    = rst_v;
  assign pll.lock       = lock_v;
  assign pll.fail       = fail_v;
  assign pll.icpsel     = icp_v;
  assign pll.relock_cnt = relock_v;
  assign pll.lpfres     = {CHANNELS{LPF_RES}};
  assign pll.all_lock   = all_lock_q;

endmodule

// File: tb/tb_pll_init_multi.sv
// tb_pll_init_multi
// Directed bench for pll_init_multi: a 2-channel default instance and a
// 1-channel instance with ICP_BASE=60 and short timing for the saturation case.
module tb_pll_init_multi;

  logic clk = 1'b0;
  logic resetn;
  logic rst2_n;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  pll_init_multi_if #(.CHANNELS(2)) bus ();
  pll_init_multi_if #(.CHANNELS(1)) bus2 ();

  pll_init_multi #(.CHANNELS(2)) dut (
    .init_clk (clk),
    .resetn   (resetn),
    .pll      (bus)
  );

  pll_init_multi #(
    .CHANNELS    (1),
    .RST_CYC     (4),
    .LOCK_TO_CYC (100),
    .STABLE_CYC  (16),
    .ICP_BASE    (60)
  ) dut2 (
    .init_clk (clk),
    .resetn   (rst2_n),
    .pll      (bus2)
  );

  typedef struct {
    int         n;
    logic       rst;
    logic [5:0] icp;
    logic       fl;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Advance to 1 time unit after the n-th clock edge since the last reset release.
  task automatic go(input int n);
    bit moved;
    moved = 1'b0;
    while (cyc < n) begin
      @(posedge clk);
      cyc++;
      moved = 1'b1;
    end
    if (moved) #1;
  endtask

  initial begin
    for (int k = 1; k < 8; k++) begin
      vt.push_back('{n: 5051*k - 1,  rst: 1'b0, icp: 6'(8 + 4*(k-1)), fl: 1'b0});
      vt.push_back('{n: 5051*k,      rst: 1'b1, icp: 6'(8 + 4*k),     fl: 1'b0});
      vt.push_back('{n: 5051*k + 49, rst: 1'b1, icp: 6'(8 + 4*k),     fl: 1'b0});
      vt.push_back('{n: 5051*k + 50, rst: 1'b0, icp: 6'(8 + 4*k),     fl: 1'b0});
    end
    vt.push_back('{n: 40407, rst: 1'b0, icp: 6'd36, fl: 1'b0});
    vt.push_back('{n: 40408, rst: 1'b1, icp: 6'd36, fl: 1'b1});

    resetn = 1'b1;
    rst2_n = 1'b1;
    bus.pll_lock  = '0;
    bus.recal     = '0;
    bus2.pll_lock = '0;
    bus2.recal    = '0;
    #1;
    resetn = 1'b0;
    rst2_n = 1'b0;
    #1;
    chk("rst_pll_rst",  32'(bus.pll_rst),    32'h3);
    chk("rst_icpsel",   32'(bus.icpsel),     32'h208);
    chk("rst_lpfres",   32'(bus.lpfres),     32'h12);
    chk("rst_lock",     32'(bus.lock),       32'h0);
    chk("rst_all_lock", 32'(bus.all_lock),   32'h0);
    chk("rst_fail",     32'(bus.fail),       32'h0);
    chk("rst_relock",   32'(bus.relock_cnt), 32'h0);

    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc = 0;

    go(49);   chk("hold_end_rst", 32'(bus.pll_rst), 32'h3);
    go(50);   chk("wait_rst",     32'(bus.pll_rst), 32'h0);
              chk("wait_icpsel",  32'(bus.icpsel),  32'h208);

    go(1000); bus.pll_lock[0] = 1'b1;
    go(1257); chk("ch0_prelock", 32'(bus.lock[0]), 32'h0);
    go(1258); chk("ch0_lock",    32'(bus.lock[0]), 32'h1);
              chk("ch0_icp",     32'(bus.icpsel[5:0]), 32'd8);
              chk("ch0_fail",    32'(bus.fail[0]), 32'h0);
              chk("all_lock_0",  32'(bus.all_lock), 32'h0);

    go(2000); bus.pll_lock[0] = 1'b0;
    go(2003); bus.pll_lock[0] = 1'b1;
    go(2010); chk("glitch_lock",   32'(bus.lock[0]), 32'h1);
              chk("glitch_rst",    32'(bus.pll_rst[0]), 32'h0);
              chk("glitch_relock", 32'(bus.relock_cnt[3:0]), 32'h0);

    go(3000); bus.pll_lock[0] = 1'b0;
    go(3004); bus.pll_lock[0] = 1'b1;
    go(3005); chk("drop_lock_hold", 32'(bus.lock[0]), 32'h1);
    go(3006); chk("drop_lock",      32'(bus.lock[0]), 32'h0);
              chk("drop_rst",       32'(bus.pll_rst[0]), 32'h1);
              chk("drop_relock",    32'(bus.relock_cnt[3:0]), 32'h1);
              chk("drop_icp",       32'(bus.icpsel[5:0]), 32'd8);
    go(3055); chk("drop_hold_end",  32'(bus.pll_rst[0]), 32'h1);
    go(3056); chk("drop_wait",      32'(bus.pll_rst[0]), 32'h0);
    go(3311); chk("relock_pre",     32'(bus.lock[0]), 32'h0);
    go(3312); chk("relock",         32'(bus.lock[0]), 32'h1);

    go(3400); bus.recal[0] = 1'b1;
    go(3401); bus.recal[0] = 1'b0;
              chk("recal_lk_lock", 32'(bus.lock[0]), 32'h0);
              chk("recal_lk_rst",  32'(bus.pll_rst[0]), 32'h1);
    go(3500); chk("stable_lock",   32'(bus.lock[0]), 32'h0);
              chk("stable_rst",    32'(bus.pll_rst[0]), 32'h0);
              bus.recal[0] = 1'b1;
    go(3501); bus.recal[0] = 1'b0;
              chk("recal_st_rst",  32'(bus.pll_rst[0]), 32'h1);
              chk("recal_st_icp",  32'(bus.icpsel[5:0]), 32'd8);
    go(3806); chk("recal_st_pre",  32'(bus.lock[0]), 32'h0);
    go(3807); chk("recal_st_lock", 32'(bus.lock[0]), 32'h1);
              chk("recal_relock",  32'(bus.relock_cnt[3:0]), 32'h1);

    go(4000); bus.recal[0] = 1'b1;
    go(4090); chk("recal_held",    32'(bus.pll_rst[0]), 32'h1);
    go(4100); bus.recal[0] = 1'b0;
    go(4149); chk("recal_rel_hold", 32'(bus.pll_rst[0]), 32'h1);
    go(4150); chk("recal_rel_wait", 32'(bus.pll_rst[0]), 32'h0);
    go(4406); chk("recal_rel_lock", 32'(bus.lock[0]), 32'h1);

    for (int i = 0; i < vt.size(); i++) begin
      go(vt[i].n);
      chk($sformatf("sweep_rst_%0d", vt[i].n),  32'(bus.pll_rst[1]),  32'(vt[i].rst));
      chk($sformatf("sweep_icp_%0d", vt[i].n),  32'(bus.icpsel[11:6]), 32'(vt[i].icp));
      chk($sformatf("sweep_fail_%0d", vt[i].n), 32'(bus.fail[1]),     32'(vt[i].fl));
    end
    chk("ch0_unaffected", 32'(bus.lock[0]), 32'h1);
    chk("ch1_no_lock",    32'(bus.lock[1]), 32'h0);

    go(40500); chk("fail_before_recal", 32'(bus.fail[1]), 32'h1);
               bus.recal = 2'b11;
               bus.pll_lock[0] = 1'b0;
    go(40501); bus.recal = 2'b00;
               chk("recal_fail_clr", 32'(bus.fail[1]), 32'h0);
               chk("recal_fail_rst", 32'(bus.pll_rst[1]), 32'h1);
               chk("recal_fail_icp", 32'(bus.icpsel[11:6]), 32'd8);
    go(40600); chk("both_wait_rst",  32'(bus.pll_rst), 32'h0);
               chk("pre_rst_relock", 32'(bus.relock_cnt), 32'h01);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_pll_rst", 32'(bus.pll_rst),    32'h3);
    chk("async_icpsel",  32'(bus.icpsel),     32'h208);
    chk("async_lock",    32'(bus.lock),       32'h0);
    chk("async_fail",    32'(bus.fail),       32'h0);
    chk("async_relock",  32'(bus.relock_cnt), 32'h0);
    chk("async_lpfres",  32'(bus.lpfres),     32'h12);

    @(posedge clk);
    #1;
    rst2_n = 1'b1;
    cyc = 0;
    chk("sat_k0_icp", 32'(bus2.icpsel),  32'd60);
    chk("sat_k0_rst", 32'(bus2.pll_rst), 32'h1);
    go(104);  chk("sat_next_rst", 32'(bus2.pll_rst), 32'h0);
              chk("sat_next_icp", 32'(bus2.icpsel),  32'd60);
    go(105);  chk("sat_k1_icp",   32'(bus2.icpsel),  32'd63);
              chk("sat_k1_rst",   32'(bus2.pll_rst), 32'h1);
    go(210);  chk("sat_k2_icp",   32'(bus2.icpsel),  32'd63);
              chk("sat_k2_rst",   32'(bus2.pll_rst), 32'h1);
    go(220);  bus2.pll_lock = 1'b1;
    go(237);  chk("sat_prelock",  32'(bus2.lock), 32'h0);
    go(238);  chk("sat_lock",     32'(bus2.lock), 32'h1);
              chk("sat_lock_icp", 32'(bus2.icpsel), 32'd63);
              chk("all_lock_lag", 32'(bus2.all_lock), 32'h0);
    go(239);  chk("all_lock_set", 32'(bus2.all_lock), 32'h1);
              bus2.pll_lock = 1'b0;
    go(244);  chk("sat_loss_pre", 32'(bus2.lock), 32'h1);
    go(245);  chk("sat_loss",     32'(bus2.lock), 32'h0);
              chk("all_lock_hold", 32'(bus2.all_lock), 32'h1);
    go(246);  chk("all_lock_clr", 32'(bus2.all_lock), 32'h0);
              chk("sat_relock",   32'(bus2.relock_cnt), 32'h1);
              chk("sat_keep_icp", 32'(bus2.icpsel), 32'd63);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
